// File: rtl/fifo_mem_ctrl.sv
// ============================================================================
// fifo_mem_ctrl: pointer/flag controller and round-robin write arbiter for a
// dual-port FIFO storage array.  Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_mem_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_LEVEL   = 6
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic                  mem_we,
  output logic [PTR_WIDTH-1:0]  mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic [PTR_WIDTH-1:0]  mem_raddr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [PTR_WIDTH:0]    count
);

  typedef enum logic [0:0] {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } state_t;

  localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_THR  = (PTR_WIDTH+1)'(AF_LEVEL);

  state_t               state_q, state_d;
  logic [PTR_WIDTH:0]   wptr_q, wptr_d;
  logic [PTR_WIDTH:0]   rptr_q, rptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 af_q, af_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_ok;
  logic                 rd_ok;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    // Both acceptances use this cycle's registered flags, so a same-cycle
    // read never makes room for a write and vice versa.
    wr_ok      = (req0 | req1) & ~full_q & ~wrst;
    rd_ok      = rd_req & ~empty_q & ~wrst;

    if (wr_ok) begin
      gnt0 = req0 & (~req1 | (state_q == PRI0));
      gnt1 = req1 & (~req0 | (state_q == PRI1));
      wptr_d = wptr_q + PTR_ONE;
    end
    if (gnt0) begin
      state_d = PRI1;
    end else if (gnt1) begin
      state_d = PRI0;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    // Pointer difference equals occupancy; full means the pointers differ
    // only in the wrap bit, i.e. the difference is exactly DEPTH.
    count_d    = wptr_d - rptr_d;
    full_d     = (count_d == DEPTH_C);
    empty_d    = (wptr_d == rptr_d);
    af_d       = (count_d >= AF_THR);
    rd_valid_d = rd_ok;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= PRI0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // A read launched just before reset is dropped rather than reported.
  assign rd_valid    = rd_valid_q & ~wrst;
  assign mem_we      = gnt0 | gnt1;
  assign mem_waddr   = wptr_q[PTR_WIDTH-1:0];
  assign mem_wdata   = gnt1 ? wdata1 : wdata0;
  assign mem_re      = rd_ok;
  assign mem_raddr   = rptr_q[PTR_WIDTH-1:0];
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_mem_ctrl.sv
// ============================================================================
// tb_fifo_mem_ctrl: directed bench with a reference model and data scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_mem_ctrl;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic       gnt0, gnt1, rd_valid, mem_we, mem_re;
  logic [2:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata;
  logic       full, empty, almost_full;
  logic [3:0] count;

  logic [7:0] mem [8];
  logic [7:0] mem_rdata;

  int         total = 0;
  int         bad = 0;
  logic [3:0] m_wp = 4'd0;
  logic [3:0] m_rp = 4'd0;
  bit         m_pri = 1'b0;
  bit         m_rdv = 1'b0;
  logic [7:0] sb[$];

  always #5 wclk = ~wclk;

  fifo_mem_ctrl #(
    .DEPTH(8), .DATA_WIDTH(8), .PTR_WIDTH(3), .AF_LEVEL(6)
  ) dut (
    .wclk(wclk), .wrst(wrst),
    .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rd_req(rd_req), .rd_valid(rd_valid),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count)
  );

  // Storage array: registered read, as seen by the consumer.
  always @(posedge wclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, advance the model at the edge, then check registered state.
  task automatic cyc(input bit r0, input bit r1, input bit rd, input bit rst,
                     input logic [7:0] d0, input logic [7:0] d1);
    bit         full_e, empty_e, g0, g1, re_e, rdv_e;
    logic [3:0] cnt_e;
    @(negedge wclk);
    req0 = r0; req1 = r1; rd_req = rd; wrst = rst; wdata0 = d0; wdata1 = d1;
    #1;
    full_e  = ((m_wp ^ m_rp) == 4'b1000);
    empty_e = (m_wp == m_rp);
    g0   = !rst && !full_e && r0 && (!r1 || !m_pri);
    g1   = !rst && !full_e && r1 && (!r0 || m_pri);
    re_e = !rst && rd && !empty_e;
    rdv_e = m_rdv && !rst;
    chk("gnt0", {31'd0, gnt0}, {31'd0, g0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, g1});
    chk("mem_we", {31'd0, mem_we}, {31'd0, g0 | g1});
    chk("mem_re", {31'd0, mem_re}, {31'd0, re_e});
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, rdv_e});
    if (rdv_e) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $error("FAIL rdata_underflow observed=%0h expected=none", mem_rdata);
      end else begin
        chk("rdata", {24'd0, mem_rdata}, {24'd0, sb.pop_front()});
      end
    end
    if (g0 || g1) begin
      chk("waddr", {29'd0, mem_waddr}, {29'd0, m_wp[2:0]});
      chk("wdata", {24'd0, mem_wdata}, {24'd0, g0 ? d0 : d1});
      sb.push_back(g0 ? d0 : d1);
    end
    if (re_e) chk("raddr", {29'd0, mem_raddr}, {29'd0, m_rp[2:0]});
    @(posedge wclk);
    if (rst) begin
      m_wp = 4'd0; m_rp = 4'd0; m_pri = 1'b0; m_rdv = 1'b0;
      sb.delete();
    end else begin
      if (g0 || g1) m_wp = m_wp + 4'd1;
      if (re_e) m_rp = m_rp + 4'd1;
      if (g0) m_pri = 1'b1;
      else if (g1) m_pri = 1'b0;
      m_rdv = re_e;
    end
    #1;
    cnt_e = m_wp - m_rp;
    chk("count", {28'd0, count}, {28'd0, cnt_e});
    chk("full", {31'd0, full}, {31'd0, cnt_e == 4'd8});
    chk("empty", {31'd0, empty}, {31'd0, cnt_e == 4'd0});
    chk("almost_full", {31'd0, almost_full}, {31'd0, cnt_e >= 4'd6});
  endtask

  initial begin
    // Reset with every request asserted.
    cyc(1, 1, 1, 1, 8'h11, 8'h22);
    cyc(1, 1, 1, 1, 8'h11, 8'h22);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {28'd0, count}, 32'd0);

    // Contention on an empty FIFO: grants alternate, then refusal at full.
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, 0, 0, 8'hA0 + 8'(i), 8'hB0 + 8'(i));
      if (i == 7) begin
        chk("cont_full", {31'd0, full}, 32'd1);
        chk("cont_count8", {28'd0, count}, 32'd8);
      end
    end
    chk("cont_nogrant", {31'd0, gnt0 | gnt1}, 32'd0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 8'h00, 8'h00);

    // Fill, then ten reads: last two refused.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'($urandom), 8'h00);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Full boundary: simultaneous write and read at count 8.
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 8'h00, 8'($urandom));
    cyc(1, 0, 1, 0, 8'hEE, 8'h00);
    chk("fb_count7", {28'd0, count}, 32'd7);
    chk("fb_notfull", {31'd0, full}, 32'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 8'h00, 8'h00);

    // Pointer wrap with single write/read pairs; requester picked at random.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(1) == 0) cyc(1, 0, 0, 0, 8'($urandom), 8'h00);
      else                        cyc(0, 1, 0, 0, 8'h00, 8'($urandom));
      cyc(0, 0, 1, 0, 8'h00, 8'h00);
      total++;
      assert (count <= 4'd1) else begin
        bad++;
        $error("FAIL wrap_count observed=%0d expected<=1", count);
      end
    end
    cyc(0, 0, 0, 0, 8'h00, 8'h00);

    // Mid-stream reset right after an accepted read.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'h60 + 8'(i), 8'h00);
    chk("mr_count5", {28'd0, count}, 32'd5);
    cyc(0, 0, 1, 0, 8'h00, 8'h00);
    cyc(1, 1, 1, 1, 8'h77, 8'h88);
    chk("mr_count0", {28'd0, count}, 32'd0);
    chk("mr_empty", {31'd0, empty}, 32'd1);
    cyc(1, 0, 0, 0, 8'h5A, 8'h00);
    cyc(0, 0, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    chk("mr_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fifo_mem_ctrl.md
# fifo_mem_ctrl

Single-clock controller that sequences a dual-port FIFO storage array (registered read, write gated by `full`, read gated by `empty`) and shares its write port between two requesters. It owns the write/read pointers, occupancy count and status flags, arbitrates the two write sources round-robin, and drives the storage array's write enable, addresses and data. It sits between two producer blocks and one consumer in the synchronous (non-CDC) FIFO path.

## Interface
- `DEPTH`, 8, number of storage entries; power of two.
- `DATA_WIDTH`, 8, data word width.
- `PTR_WIDTH`, 3, address width; `DEPTH == 2**PTR_WIDTH`.
- `AF_LEVEL`, 6, `almost_full` threshold in entries, 1..DEPTH.

- `wclk`  in  1  sole clock; all state updates on rising edge.
- `wrst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1 each  write request from requester 0 / 1.
- `wdata0`, `wdata1`  in  DATA_WIDTH each  write data from requester 0 / 1.
- `gnt0`, `gnt1`  out  1 each  combinational grant; a write is accepted on a cycle where grant is high.
- `rd_req`  in  1  consumer read request.
- `rd_valid`  out  1  registered; high one cycle after an accepted read, when `mem_rdata` is valid.
- `mem_we`  out  1  storage write enable (`gnt0 | gnt1`).
- `mem_waddr`  out  PTR_WIDTH  storage write address.
- `mem_wdata`  out  DATA_WIDTH  muxed data of the granted requester.
- `mem_re`  out  1  storage read enable (accepted read).
- `mem_raddr`  out  PTR_WIDTH  storage read address.
- `full`, `empty`, `almost_full`  out  1 each  registered status flags.
- `count`  out  PTR_WIDTH+1  registered occupancy, 0..DEPTH.

## Operation
- Pointers `wptr`, `rptr` are PTR_WIDTH+1 bits binary; the low PTR_WIDTH bits drive `mem_waddr`/`mem_raddr`, and the MSB is the wrap bit.
- `full` is high when the pointers differ only in the MSB. `empty` is high when `wptr == rptr`. `almost_full` is high when `count >= AF_LEVEL`.
- Write acceptance: `wr_ok = (req0 | req1) & !full`, using the registered `full` of the current cycle. A same-cycle read does not free space for a write.
- Read acceptance: `mem_re = rd_req & !empty`. A same-cycle write does not make data readable.
- Arbiter is a two-state FSM, PRI0 and PRI1.
  - Only one requester active: that requester is granted.
  - Both active: the priority holder is granted.
  - Grant to 0 moves the FSM to PRI1; grant to 1 moves it to PRI0.
  - No grant (no requests, or `full`): state holds.
- At most one grant per cycle. Grants are never asserted while `full`.
- On accepted write: `wptr <= wptr + 1`, wrapping modulo 2**(PTR_WIDTH+1).
- On accepted read: `rptr <= rptr + 1`.
- `count`: +1 on write only, −1 on read only, unchanged on both or neither.
- All flags are recomputed from the next-state pointers and registered, so they are valid in the cycle after the update.
- Reset, applied at any time including mid-stream:
  - pointers = 0, `count` = 0, `empty` = 1, `full` = 0, `almost_full` = 0;
  - FSM = PRI0, `rd_valid` = 0;
  - combinational outputs (`gnt*`, `mem_we`, `mem_re`) forced to 0 while `wrst` is high.
  - Storage contents are not cleared. In-flight reads are dropped: no `rd_valid` in the cycle after reset.

## Timing
- Grant, `mem_we`, `mem_waddr` and `mem_wdata` are combinational in the request cycle. The storage array captures data on that cycle's edge.
- Read latency is 1 cycle: `mem_re` in cycle N gives `rd_valid` = 1 in cycle N+1, aligned with the storage array's registered `mem_rdata`.
- Flag and count latency is 1 cycle from the accepting edge.
- Back-to-back operation: one write and one read per cycle sustained, with no bubbles.
- Full FIFO with simultaneous requests: the write is refused and the read is accepted; next cycle `full` = 0 and `count` = DEPTH−1.
- Empty FIFO with simultaneous requests: the read is refused and the write is accepted; next cycle `empty` = 0 and `count` = 1.

## Test plan
- Reset check: assert `wrst` with `req0` = `req1` = `rd_req` = 1. All grants, `mem_we` and `mem_re` must be 0; `empty` = 1, `count` = 0, `rd_valid` = 0.
- Contention: hold `req0` and `req1` high continuously on an empty FIFO with `wdata0` = 0xA0+i and `wdata1` = 0xB0+i. Grants must alternate 0,1,0,1…; after 8 cycles `full` = 1 and `count` = 8; the next cycle has no grant.
- Fill, then read out: write 8 words, then assert `rd_req` for 10 cycles. Expect 8 `mem_re` pulses at addresses 0..7 and 8 `rd_valid` pulses, each one cycle later. `empty` = 1 after the 8th read, and the final 2 requests are refused.
- Full-boundary simultaneity: at `count` = 8, assert `req0` and `rd_req` together. The write must be refused and the read accepted; the next cycle gives `count` = 7 and `full` = 0.
- Pointer wrap: run 20 interleaved single-write/single-read pairs. `mem_waddr` must wrap 7→0 and `mem_raddr` likewise; data order must be preserved; `count` stays 0 or 1.
- Mid-stream reset: with `count` = 5 and a read accepted in cycle N, assert `wrst` in cycle N+1. Expect `rd_valid` = 0 in cycle N+1, `count` = 0 and `empty` = 1 after reset, and a subsequent write to land at `mem_waddr` = 0.
